// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand and result handshake bundle for alu_exec_unit
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            branch_taken;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, branch_taken
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, zero, branch_taken
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative shifter
// ALU_BARREL_SHIFT_EN: shifts complete combinationally at accept instead of 1 bit/cycle.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_exec_unit_if.slave   bus
);
  localparam int SW = $clog2(XLEN);

  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b10100;
  localparam logic [4:0] OP_SRA  = 5'b10110;
  localparam logic [4:0] OP_OR   = 5'b11000;
  localparam logic [4:0] OP_BGE  = 5'b11010;
  localparam logic [4:0] OP_AND  = 5'b11100;
  localparam logic [4:0] OP_BGEU = 5'b11110;
  localparam logic [4:0] OP_LUI  = 5'b11111;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            br_q;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic            alu_br;

  assign shamt = bus.b[SW-1:0];

`ifndef ALU_BARREL_SHIFT_EN
  logic [4:0]      code_q;
  logic [SW-1:0]   cnt_q;
  logic            is_shift;
  logic [XLEN-1:0] step_res;

  function automatic logic [XLEN-1:0] shift1(input logic [4:0] code, input logic [XLEN-1:0] v);
    case (code)
      OP_SLL:  shift1 = {v[XLEN-2:0], 1'b0};
      OP_SRA:  shift1 = {v[XLEN-1], v[XLEN-1:1]};
      default: shift1 = {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                    (bus.alu_control == OP_SRA);
  assign step_res = shift1(code_q, result_q);
`endif

  always_comb begin
    alu_res = bus.a + bus.b;
    case (bus.alu_control)
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      OP_BGE:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) >= $signed(bus.b)};
      OP_BGEU: alu_res = {{(XLEN-1){1'b0}}, bus.a >= bus.b};
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_LUI:  alu_res = bus.b;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(bus.a) >>> shamt);
`else
      // The accept edge performs the first shift step, so shamt==1 finishes here too
      OP_SLL, OP_SRL, OP_SRA:
        alu_res = (shamt == '0) ? bus.a : shift1(bus.alu_control, bus.a);
`endif
      default: alu_res = bus.a + bus.b;
    endcase
    alu_zero = (alu_res == '0);
    case (bus.alu_control)
      OP_SUB:                          alu_br = alu_zero;
      OP_XOR:                          alu_br = !alu_zero;
      OP_SLT, OP_SLTU, OP_BGE, OP_BGEU: alu_br = alu_res[0];
      default:                         alu_br = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
`ifdef ALU_BARREL_SHIFT_EN
            state_d = S_DONE;
`else
            state_d = (is_shift && (shamt > SW'(1))) ? S_SHIFT : S_DONE;
`endif
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        S_SHIFT: if (cnt_q == SW'(1)) state_d = S_DONE;
`endif
        S_DONE:  if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // result_q doubles as the shift register while in SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      code_q   <= '0;
      cnt_q    <= '0;
`endif
    end else if (!flush) begin
      if (state_q == S_IDLE && bus.in_valid) begin
        result_q <= alu_res;
        zero_q   <= alu_zero;
        br_q     <= alu_br;
`ifndef ALU_BARREL_SHIFT_EN
        code_q   <= bus.alu_control;
        cnt_q    <= shamt - SW'(1);
      end else if (state_q == S_SHIFT) begin
        result_q <= step_res;
        cnt_q    <= cnt_q - SW'(1);
        zero_q   <= (step_res == '0);
        br_q     <= 1'b0;
`endif
      end
    end
  end

  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.branch_taken = br_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        br;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] code, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    exp_lat = 1;
`else
    if ((code == 5'b00100 || code == 5'b10100 || code == 5'b10110) && b[4:0] > 5'd1)
      exp_lat = int'(b[4:0]);
    else
      exp_lat = 1;
`endif
  endfunction

  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) chk("issue_timeout", 32'(guard), 32'd0);
    bus.alu_control = code;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat;
    logic seen;
    bus.in_valid = 1'b0;
    bus.alu_control = 5'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    vecs[1]  = '{5'b00010, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b1};
    vecs[2]  = '{5'b10000, 32'h00000005, 32'h00000006, 32'h00000003, 1'b0, 1'b1};
    vecs[3]  = '{5'b10110, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[4]  = '{5'b00100, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0};
    vecs[5]  = '{5'b11111, 32'h55555555, 32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0};
    vecs[6]  = '{5'b11010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{5'b11110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1};
    vecs[8]  = '{5'b01000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1};
    vecs[9]  = '{5'b01100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{5'b10100, 32'hF0000000, 32'd4,        32'h0F000000, 1'b0, 1'b0};
    vecs[11] = '{5'b00100, 32'h00000001, 32'd35,       32'h00000008, 1'b0, 1'b0};
    vecs[12] = '{5'b11000, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0};
    vecs[13] = '{5'b11100, 32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0};
    vecs[14] = '{5'b00001, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0};
    vecs[15] = '{5'b00010, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[16] = '{5'b10000, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vecs[17] = '{5'b10110, 32'h40000000, 32'd2,        32'h10000000, 1'b0, 1'b0};
    vecs[18] = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[19] = '{5'b10100, 32'h80000001, 32'd1,        32'h40000000, 1'b0, 1'b0};
    vecs[20] = '{5'b11010, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b1};

    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_branch", 32'(bus.branch_taken), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].code, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].code, vecs[i].b)));
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_branch", i), 32'(bus.branch_taken), 32'(vecs[i].br));
      @(posedge clk); #1;
    end

    // Backpressure: result must hold while the consumer stalls
    bus.out_ready = 1'b0;
    issue(5'b00000, 32'd10, 32'd20);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_result", k), bus.result, 32'd30);
      chk($sformatf("hold%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush on cycle 3 of a 20-cycle SRL
    bus.out_ready = 1'b0;
    issue(5'b10100, 32'hFFFFFFFF, 32'd20);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_out_valid", 32'(seen), 32'd0);
    bus.out_ready = 1'b1;

    // Asynchronous reset in the middle of a long shift
    issue(5'b10110, 32'h80000000, 32'd31);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_zero", 32'(bus.zero), 32'd0);
    chk("arst_branch", 32'(bus.branch_taken), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(5'b11000, 32'h0000A000, 32'h00000505);
    wait_valid(lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_result", bus.result, 32'h0000A505);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
